// File: rtl/seg7_pkg.sv
// Shared segment patterns (active-low, a..g left to right), result codes and
// scan-reader FSM states.
package seg7_pkg;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_B     = 7'b1100000;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_F     = 7'b0111000;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to {code, err} lookup.
// Define SEG7_HEX_EN to also accept the A..F letter patterns.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [0:6] pattern,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = CODE_ERR;
        err  = 1'b1;
        case (pattern)
            SEG_0:     begin code = 4'h0;       err = 1'b0; end
            SEG_1:     begin code = 4'h1;       err = 1'b0; end
            SEG_2:     begin code = 4'h2;       err = 1'b0; end
            SEG_3:     begin code = 4'h3;       err = 1'b0; end
            SEG_4:     begin code = 4'h4;       err = 1'b0; end
            SEG_5:     begin code = 4'h5;       err = 1'b0; end
            SEG_6:     begin code = 4'h6;       err = 1'b0; end
            SEG_7:     begin code = 4'h7;       err = 1'b0; end
            SEG_8:     begin code = 4'h8;       err = 1'b0; end
            SEG_9:     begin code = 4'h9;       err = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
`ifdef SEG7_HEX_EN
            // Hex F and blank share code F by design.
            SEG_A:     begin code = 4'hA;       err = 1'b0; end
            SEG_B:     begin code = 4'hB;       err = 1'b0; end
            SEG_C:     begin code = 4'hC;       err = 1'b0; end
            SEG_D:     begin code = 4'hD;       err = 1'b0; end
            SEG_E:     begin code = 4'hE;       err = 1'b0; end
            SEG_F:     begin code = 4'hF;       err = 1'b0; end
`endif
            default:   begin code = CODE_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus and delivers
// whole frames on a valid/ready output. SEG7_HEX_EN enables hex letter decode.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:6]            seg_i,
    input  logic [N_DIGITS-1:0]   an_i,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*N_DIGITS-1:0] bcd_o,
    output logic [N_DIGITS-1:0]   err_o,
    output logic                  overrun_o
);

    localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]       CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]       CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] MASK_FULL = '1;

    logic [0:6]            seg_q;
    logic [N_DIGITS-1:0]   an_q;
    scan_state_t           state, state_n;
    logic [SW-1:0]         sel, sel_n;
    logic [N_DIGITS-1:0]   an_ref, an_ref_n;
    logic [0:6]            ref_pat, ref_pat_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [N_DIGITS-1:0]   mask, mask_n;
    logic [4*N_DIGITS-1:0] shadow_bcd, shadow_bcd_n;
    logic [N_DIGITS-1:0]   shadow_err, shadow_err_n;
    logic                  an_valid;
    logic [SW-1:0]         an_idx;
    logic                  capture;
    logic                  complete;
    logic [3:0]            dec_code;
    logic                  dec_err;

    seg7_pattern_decode u_decode (
        .pattern (seg_q),
        .code    (dec_code),
        .err     (dec_err)
    );

    assign an_valid = $onehot(~an_q);

    always_comb begin
        an_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) an_idx = SW'(i);
        end
    end

    // A changed anode selection is handled exactly like IDLE in the same cycle.
    always_comb begin
        state_n   = state;
        sel_n     = sel;
        an_ref_n  = an_ref;
        ref_pat_n = ref_pat;
        cnt_n     = cnt;
        capture   = 1'b0;
        if (state == IDLE || an_q != an_ref) begin
            state_n = IDLE;
            if (an_valid) begin
                state_n   = TRACK;
                sel_n     = an_idx;
                an_ref_n  = an_q;
                ref_pat_n = seg_q;
                cnt_n     = CNT_ONE;
                if (STABLE_CYCLES == 1) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end
            end
        end else if (state == TRACK) begin
            if (seg_q != ref_pat) begin
                ref_pat_n = seg_q;
                cnt_n     = CNT_ONE;
            end else if (cnt == CNT_LAST) begin
                cnt_n   = cnt + CNT_ONE;
                capture = 1'b1;
                state_n = HOLD;
            end else begin
                cnt_n = cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        mask_n       = mask;
        shadow_bcd_n = shadow_bcd;
        shadow_err_n = shadow_err;
        if (capture) begin
            mask_n[sel_n]               = 1'b1;
            shadow_bcd_n[4*sel_n +: 4] = dec_code;
            shadow_err_n[sel_n]         = dec_err;
        end
        complete = capture && (mask_n == MASK_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            an_q       <= '0;
            state      <= IDLE;
            sel        <= '0;
            an_ref     <= '0;
            ref_pat    <= '0;
            cnt        <= '0;
            mask       <= '0;
            shadow_bcd <= '0;
            shadow_err <= '0;
            out_valid  <= 1'b0;
            bcd_o      <= '0;
            err_o      <= '0;
            overrun_o  <= 1'b0;
        end else begin
            seg_q      <= seg_i;
            an_q       <= an_i;
            state      <= state_n;
            sel        <= sel_n;
            an_ref     <= an_ref_n;
            ref_pat    <= ref_pat_n;
            cnt        <= cnt_n;
            shadow_bcd <= shadow_bcd_n;
            shadow_err <= shadow_err_n;
            overrun_o  <= 1'b0;
            if (complete) begin
                // A completing frame always wins; only an unconsumed one is flagged.
                mask      <= '0;
                bcd_o     <= shadow_bcd_n;
                err_o     <= shadow_err_n;
                out_valid <= 1'b1;
                overrun_o <= out_valid && !out_ready;
            end else begin
                mask <= mask_n;
                if (out_valid && out_ready) out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scans plus random scanning
// against a pin-level reference model, with a queue-based frame scoreboard.
module tb_seg7_scan_reader;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int FW = 5 * N;

    localparam logic [6:0] P_BLANK = 7'b1111111;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [6:0]     seg_i;
    logic [N-1:0]   an_i;
    logic           out_ready;
    logic           out_valid;
    logic [4*N-1:0] bcd_o;
    logic [N-1:0]   err_o;
    logic           overrun_o;

    seg7_scan_reader #(.N_DIGITS(N), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_i     (seg_i),
        .an_i      (an_i),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bcd_o     (bcd_o),
        .err_o     (err_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ovr = 0;
    logic [FW-1:0] exp_q[$];
    bit rand_ready = 1'b0;

    logic [6:0] dig_pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [6:0] hex_pat [6]  = '{7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
                                 7'b0111000};
    logic [N-1:0] bad_an [5] = '{4'b1111, 4'b0011, 4'b0000, 4'b1010, 4'b0110};

    // Reference model: runs of identical pins on one selected digit.
    logic [N-1:0]   m_prev_an;
    logic [6:0]     m_prev_seg;
    int             m_run;
    bit             m_capt;
    logic [N-1:0]   m_mask;
    logic [4*N-1:0] m_bcd;
    logic [N-1:0]   m_err;

    function automatic logic [4:0] model_decode(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (p == dig_pat[d]) return {1'b0, 4'(d)};
        if (p == P_BLANK) return {1'b0, 4'hF};
`ifdef SEG7_HEX_EN
        for (int h = 0; h < 6; h++) if (p == hex_pat[h]) return {1'b0, 4'(10 + h)};
`endif
        return {1'b1, 4'hE};
    endfunction

    task automatic model_reset();
        m_prev_an = '1;
        m_prev_seg = '0;
        m_run = 0;
        m_capt = 1'b0;
        m_mask = '0;
        m_bcd = '0;
        m_err = '0;
    endtask

    task automatic model_step(input logic [N-1:0] an, input logic [6:0] seg);
        logic [4:0] d;
        int idx;
        if ($countones(~an) == 1) begin
            if (an == m_prev_an) begin
                if (seg == m_prev_seg) m_run++;
                else m_run = 1;
            end else begin
                m_run = 1;
                m_capt = 1'b0;
            end
            m_prev_an = an;
            m_prev_seg = seg;
            if (!m_capt && m_run >= SC) begin
                m_capt = 1'b1;
                idx = 0;
                for (int i = 0; i < N; i++) if (!an[i]) idx = i;
                d = model_decode(seg);
                m_bcd[4*idx +: 4] = d[3:0];
                m_err[idx] = d[4];
                m_mask[idx] = 1'b1;
                if (&m_mask) begin
                    exp_q.push_back({m_bcd, m_err});
                    m_mask = '0;
                end
            end
        end else begin
            m_prev_an = '1;
            m_run = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic [N-1:0] an, input logic [6:0] seg);
        an_i = an;
        seg_i = seg;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        model_step(an, seg);
        @(posedge clk);
        #1;
    endtask

    task automatic hold_digit(input int idx, input logic [6:0] seg, input int len);
        logic [N-1:0] an;
        an = '1;
        an[idx] = 1'b0;
        repeat (len) drive_cycle(an, seg);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        hold_digit(0, p0, 6);
        hold_digit(1, p1, 6);
        hold_digit(2, p2, 6);
        hold_digit(3, p3, 6);
    endtask

    // Checks a frame presented under back-pressure, then accepts it.
    task automatic check_frame(input string name, input logic [15:0] bcd, input logic [3:0] err);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".bcd"}, 32'(bcd_o), 32'(bcd));
        check({name, ".err"}, 32'(err_o), 32'(err));
        out_ready = 1'b1;
        drive_cycle('1, P_BLANK);
        out_ready = 1'b0;
    endtask

    function automatic logic [6:0] random_pattern();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return dig_pat[$urandom_range(0, 9)];
        if (r == 6) return P_BLANK;
        return 7'($urandom);
    endfunction

    // Scoreboard monitor: an overrun retires the overwritten frame, a transfer is compared.
    logic [FW-1:0] mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun_o) begin
                n_ovr++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL overrun: pulse seen with no frame queued");
                end else begin
                    mon_e = exp_q.pop_front();
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL transfer: got frame %h, expected no frame", {bcd_o, err_o});
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bcd_o, err_o} !== mon_e) begin
                        n_err++;
                        $display("FAIL transfer: got bcd=%h err=%b, expected bcd=%h err=%b",
                                 bcd_o, err_o, mon_e[FW-1:N], mon_e[N-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr0;
        int kind;
        int len;
        int idx;
        logic [6:0] p;

        rst_n = 1'b0;
        an_i = '1;
        seg_i = P_BLANK;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.bcd", 32'(bcd_o), 32'd0);
        check("reset.err", 32'(err_o), 32'd0);
        check("reset.overrun", 32'(overrun_o), 32'd0);

        // Pending frame plus a partial frame, then reset while tracking digit 3.
        scan4(dig_pat[5], dig_pat[5], dig_pat[5], dig_pat[5]);
        check("pend.bcd", 32'(bcd_o), 32'h5555);
        hold_digit(0, dig_pat[9], 6);
        hold_digit(1, dig_pat[9], 6);
        hold_digit(2, dig_pat[9], 6);
        hold_digit(3, dig_pat[9], 2);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.valid", 32'(out_valid), 32'd0);
        check("midreset.bcd", 32'(bcd_o), 32'd0);
        check("midreset.err", 32'(err_o), 32'd0);
        exp_q.delete();
        model_reset();
        an_i = '1;
        seg_i = P_BLANK;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Partial captures were discarded: three digits must not complete a frame.
        hold_digit(1, dig_pat[2], 6);
        hold_digit(2, dig_pat[3], 6);
        hold_digit(3, dig_pat[4], 6);
        check("postreset.novalid", 32'(out_valid), 32'd0);
        hold_digit(0, dig_pat[1], 6);
        check_frame("f1234", 16'h4321, 4'b0000);

        // Glitch on digit 0 shorter than the stability window.
        hold_digit(0, dig_pat[0], 2);
        hold_digit(0, dig_pat[3], 5);
        hold_digit(1, dig_pat[5], 6);
        hold_digit(2, dig_pat[6], 6);
        hold_digit(3, dig_pat[7], 6);
        check_frame("glitch", 16'h7653, 4'b0000);

        scan4(dig_pat[8], dig_pat[9], 7'b1111110, P_BLANK);
        check_frame("illegal", 16'hFE98, 4'b0100);

        // Invalid anode selections between digits keep the partial mask.
        hold_digit(0, dig_pat[0], 6);
        hold_digit(1, dig_pat[7], 6);
        repeat (10) drive_cycle(4'b1111, random_pattern());
        repeat (10) drive_cycle(4'b0011, dig_pat[8]);
        check("badan.novalid", 32'(out_valid), 32'd0);
        hold_digit(2, dig_pat[2], 6);
        hold_digit(3, dig_pat[6], 6);
        check_frame("badan", 16'h6270, 4'b0000);

`ifdef SEG7_HEX_EN
        scan4(hex_pat[0], hex_pat[1], hex_pat[2], hex_pat[3]);
        check_frame("hex", 16'hDCBA, 4'b0000);
`endif

        // Two frames under back-pressure: second overwrites the first.
        scan4(dig_pat[1], dig_pat[2], dig_pat[3], dig_pat[4]);
        check("bp1.valid", 32'(out_valid), 32'd1);
        check("bp1.bcd", 32'(bcd_o), 32'h4321);
        ovr0 = n_ovr;
        scan4(dig_pat[5], dig_pat[6], dig_pat[7], dig_pat[8]);
        check("bp2.valid", 32'(out_valid), 32'd1);
        check("bp2.bcd", 32'(bcd_o), 32'h8765);
        check("bp2.overruns", 32'(n_ovr - ovr0), 32'd1);
        out_ready = 1'b1;
        repeat (3) drive_cycle('1, P_BLANK);
        out_ready = 1'b0;
        check("bp.drained.valid", 32'(out_valid), 32'd0);
        check("bp.drained.queue", 32'(exp_q.size()), 32'd0);

        // Random scanning with random back-pressure.
        rand_ready = 1'b1;
        repeat (200) begin
            kind = $urandom_range(0, 9);
            len = $urandom_range(1, 8);
            p = random_pattern();
            if (kind == 0) begin
                repeat (len) drive_cycle(bad_an[$urandom_range(0, 4)], p);
            end else begin
                idx = $urandom_range(0, N - 1);
                if (kind == 1) hold_digit(idx, random_pattern(), $urandom_range(1, 3));
                hold_digit(idx, p, len);
            end
        end
        rand_ready = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            drive_cycle('1, P_BLANK);
        end
        drive_cycle('1, P_BLANK);
        check("final.queue", 32'(exp_q.size()), 32'd0);
        check("final.valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
